// File: rtl/dce_uart_pkg.sv
// Shared types and constants for the DCE-side UART receiver.
// DCE_UART_RX_PARITY_EN adds the PARITY state for 8E1 framing.
package dce_uart_pkg;

    localparam int unsigned DBR_W  = 32;
    localparam int unsigned TMR_W  = 16;
    localparam int unsigned STAT_W = 4;

    // rx_status bit positions
    localparam int unsigned ST_OVR = 0;
    localparam int unsigned ST_FRM = 1;
    localparam int unsigned ST_PAR = 2;
    localparam int unsigned ST_RTS = 3;

`ifdef DCE_UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_e;
`endif

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dce_rx_fifo.sv
// Receive FIFO with registered full/empty/count; a push into a full FIFO
// is accepted only when a pop frees the head slot in the same cycle.
module dce_rx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic [CW-1:0]     count_nxt;

    always_comb begin
        do_pop    = pop & ~empty;
        do_push   = push & (~full | do_pop);
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(FIFO_DEPTH));
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/dce_uart_rx.sv
// DCE-side UART receiver: synchronizer, 8N1 framing FSM, receive FIFO,
// cts flow control and sticky status. DCE_UART_RX_PARITY_EN selects 8E1.
module dce_uart_rx
    import dce_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic              clock10M,
    input  logic              reset,
    input  logic              rxd,
    output logic              cts,
    input  logic              rts,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [STAT_W-1:0] rx_status,
    input  logic              status_clr,
    output logic [DBR_W-1:0]  DBR
);

    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned HALF_LOAD = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_LOAD = CLKS_PER_BIT - 1;

    rx_state_e          state;
    logic               rxd_s1;
    logic               rxd_s2;
    logic               rxd_d;
    logic               fall;
    logic [TMR_W-1:0]   timer;
    logic               timer_zero;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic               push_q;
    logic               frm_set;
    logic               par_set;
    logic               ovr_set;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [STAT_W-1:0]  set_vec;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clock10M or posedge reset) begin
        if (reset) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign fall       = rxd_d & ~rxd_s2;
    assign timer_zero = (timer == '0);

    // Framing FSM; the stop sample returns to IDLE mid-stop-bit so a
    // start edge immediately after the stop bit is still caught.
    always_ff @(posedge clock10M or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            push_q  <= 1'b0;
            frm_set <= 1'b0;
            par_set <= 1'b0;
        end else begin
            push_q  <= 1'b0;
            frm_set <= 1'b0;
            par_set <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_START;
                        timer <= TMR_W'(HALF_LOAD);
                    end
                end
                S_START: begin
                    if (timer_zero) begin
                        if (!rxd_s2) begin
                            state   <= S_DATA;
                            timer   <= TMR_W'(FULL_LOAD);
                            bit_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                S_DATA: begin
                    if (timer_zero) begin
                        shreg   <= {rxd_s2, shreg[7:1]};
                        timer   <= TMR_W'(FULL_LOAD);
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef DCE_UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
`ifdef DCE_UART_RX_PARITY_EN
                S_PARITY: begin
                    if (timer_zero) begin
                        par_set <= (rxd_s2 != even_par(shreg));
                        timer   <= TMR_W'(FULL_LOAD);
                        state   <= S_STOP;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (timer_zero) begin
                        push_q  <= rxd_s2;
                        frm_set <= ~rxd_s2;
                        state   <= S_IDLE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    dce_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (8)
    ) u_fifo (
        .clk       (clock10M),
        .rst       (reset),
        .push      (push_q),
        .push_data (shreg),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rx_valid = ~fifo_empty;
    assign ovr_set  = push_q & fifo_full & ~(rx_ready & rx_valid);

    always_comb begin
        set_vec         = '0;
        set_vec[ST_RTS] = rts;
        set_vec[ST_PAR] = par_set;
        set_vec[ST_FRM] = frm_set;
        set_vec[ST_OVR] = ovr_set;
    end

    // Sticky status (set beats clear) and registered flow control.
    always_ff @(posedge clock10M or posedge reset) begin
        if (reset) begin
            rx_status <= '0;
            cts       <= 1'b0;
        end else begin
            rx_status <= (status_clr ? '0 : rx_status) | set_vec;
            cts       <= (fifo_count <= CNT_W'(FIFO_DEPTH - 3));
        end
    end

    assign DBR = DBR_W'(CLKS_PER_BIT);

endmodule
